// File: rtl/bus_read_ctrl_pkg.sv
// Shared definitions for the bus read controller: default sizes,
// address width and the 2-bit FSM state encoding.
package bus_read_ctrl_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int NREG_DEFAULT = 4;
  localparam int AW           = 2;

  // Read sequence: IDLE -> DRIVE (bus settles) -> CAPTURE (sample bus) -> DONE (result valid)
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // True in the states where exactly one tristate buffer owns the bus
  function automatic logic drives_bus(state_e s);
    return (s == DRIVE) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/bus_read_ctrl_dec2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled so
// the shared bus floats.
module dec2to4
  import bus_read_ctrl_pkg::*;
(
  input  logic          en_i,
  input  logic [AW-1:0] sel_i,
  output logic [3:0]    onehot_o
);

  // At most one output bit is ever set; none when en_i is low
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_read_ctrl.sv
// Register file with a tristate-bus read sequencer. Registers are exported
// to external tristate buffers; a read enables one buffer for a settling
// cycle and a capture cycle, then presents the sampled bus for one cycle.
//
// Handshake: rd_req is a request strobe with no back-pressure. It is
// accepted only at an edge where the FSM is IDLE (rd_busy low); a request
// seen while rd_busy is high, including the DONE cycle, is dropped, not
// queued. rd_valid is a one-cycle pulse qualifying rd_data, which then
// holds until the next capture.
module bus_read_ctrl
  import bus_read_ctrl_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  output logic [NREG*DW-1:0] reg_data,
  output logic [NREG-1:0]    read_en,
  input  logic [DW-1:0]      bus_in,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  output logic               rd_busy,
  output logic [1:0]         dbg_state
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] regs_q [NREG];
  logic          dec_en;
  logic [3:0]    dec_onehot;

  // Register file: writes land in every FSM state, reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Flatten the register file; no gating, contents are always visible
  always_comb begin
    reg_data = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_data[i*DW +: DW] = regs_q[i];
    end
  end

  // FSM state register plus latched read address and capture register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state logic: only IDLE waits on a request, the rest simply advance
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd_req) state_d = DRIVE;
      DRIVE:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch the address on acceptance; sample the bus
  // on the edge leaving CAPTURE (DRIVE is left for the bus to settle)
  always_comb begin
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    if ((state_q == IDLE) && rd_req) begin
      addr_d = rd_addr;
    end
    if (state_q == CAPTURE) begin
      rd_data_d = bus_in;
    end
  end

  // Output logic: all decoded from registered state, so reset clears it at once
  always_comb begin
    dec_en    = drives_bus(state_q);
    rd_valid  = (state_q == DONE);
    rd_busy   = (state_q != IDLE);
    dbg_state = state_q;
  end

  dec2to4 u_dec (
    .en_i     (dec_en),
    .sel_i    (addr_q),
    .onehot_o (dec_onehot)
  );

  assign read_en = dec_onehot[NREG-1:0];
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_read_ctrl.sv
// Bench for bus_read_ctrl: tristate buffers on a shared bus, directed
// scenarios, then random traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_bus_read_ctrl;
  import bus_read_ctrl_pkg::*;

  localparam int DW   = 8;
  localparam int NREG = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic rd_req = 1'b0;
  logic [1:0] rd_addr = '0;
  logic [NREG*DW-1:0] reg_data;
  logic [NREG-1:0] read_en;
  tri [DW-1:0] bus_in;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic rd_busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREG; g++) begin : g_buf
    assign bus_in = read_en[g] ? reg_data[g*DW +: DW] : 'z;
  end

  bus_read_ctrl #(.DW(DW), .NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .reg_data  (reg_data),
    .read_en   (read_en),
    .bus_in    (bus_in),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_busy   (rd_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  // A read accepted at edge k owns the bus after edges k and k+1, samples
  // the bus at edge k+2 (register values before that edge), is valid after
  // edge k+2, and the next request can be taken at edge k+4.
  logic [DW-1:0] m_regs [NREG];
  logic [DW-1:0] exp_hold;
  logic [DW-1:0] exp_q [$];
  int e        = 0;
  int acc_edge = -100;
  int next_ok  = 0;
  logic [1:0] acc_addr = '0;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) chk("onehot", 32'($onehot0(read_en)), 32'd1);

  function automatic logic [NREG*DW-1:0] model_flat();
    logic [NREG*DW-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic we, input logic [1:0] wa, input logic [DW-1:0] wd,
                      input logic rq, input logic [1:0] ra);
    int ph;
    logic [NREG-1:0] en_x;
    logic [1:0] st_x;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
    @(posedge clk);
    e++;
    if (e == acc_edge + 2) begin
      exp_hold = m_regs[acc_addr];
      exp_q.push_back(exp_hold);
    end
    if (rq && e >= next_ok) begin
      acc_edge = e;
      acc_addr = ra;
      next_ok  = e + 4;
    end
    if (we) m_regs[wa] = wd;
    #1;
    ph   = e - acc_edge;
    en_x = (ph == 0 || ph == 1) ? NREG'(1 << acc_addr) : '0;
    st_x = (ph == 0) ? DRIVE : (ph == 1) ? CAPTURE : (ph == 2) ? DONE : IDLE;
    chk("read_en", 32'(read_en), 32'(en_x));
    chk("rd_valid", 32'(rd_valid), 32'(ph == 2));
    chk("rd_busy", 32'(rd_busy), 32'(ph >= 0 && ph <= 2));
    chk("state", 32'(dbg_state), 32'(st_x));
    chk("rd_data_hold", 32'(rd_data), 32'(exp_hold));
    chk("reg_data", reg_data, model_flat());
    if (ph == 1) begin
      chk("bus_known", 32'($isunknown(bus_in)), 32'd0);
      chk("bus_value", 32'(bus_in), 32'(m_regs[acc_addr]));
    end
    if (ph == 2 && exp_q.size() > 0) chk("pulse_data", 32'(rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_read_en", 32'(read_en), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_reg_data", reg_data, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    e++;
    #1 rst = 1'b0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    exp_hold = '0;
    exp_q.delete();
    acc_edge = -100;
    next_ok  = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    exp_hold = '0;
    do_reset();

    // write 0xA5 to reg 2, then read it
    step(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    chk("s1_en_drive", 32'(read_en), 32'b0100);
    idle(1);
    chk("s1_en_capture", 32'(read_en), 32'b0100);
    idle(1);
    chk("s1_valid", 32'(rd_valid), 32'd1);
    chk("s1_data", 32'(rd_data), 32'hA5);
    idle(1);

    // rd_req held high for 12 cycles on reg 1
    step(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
      if (rd_valid) begin
        pulses++;
        chk("s2_data", 32'(rd_data), 32'h3C);
      end
    end
    chk("s2_pulses", 32'(pulses), 32'd3);
    idle(1);

    // write to reg 0 at the edge ending DRIVE is seen
    step(1'b1, 2'd0, 8'h11, 1'b0, 2'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    step(1'b1, 2'd0, 8'h22, 1'b0, 2'd0);
    idle(1);
    chk("s3_drive_wr", 32'(rd_data), 32'h22);
    idle(1);
    // write at the CAPTURE edge is not seen
    step(1'b1, 2'd0, 8'h11, 1'b0, 2'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    idle(1);
    step(1'b1, 2'd0, 8'h22, 1'b0, 2'd0);
    chk("s3_capture_wr", 32'(rd_data), 32'h11);
    idle(1);

    // reset pulsed during CAPTURE abandons the read
    step(1'b1, 2'd3, 8'h77, 1'b0, 2'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    idle(1);
    do_reset();
    idle(4);

    // second request during DRIVE is ignored
    step(1'b1, 2'd1, 8'h5A, 1'b0, 2'd0);
    step(1'b1, 2'd3, 8'hC3, 1'b0, 2'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    chk("s5_data", 32'(rd_data), 32'h5A);
    idle(4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
